// File: rtl/hex_display_monitor.sv
// hex_display_monitor: watches active-low 7-segment buses and recovers the hex
// word being shown. Each frame must hold steady before it is decoded. A stable
// frame that differs from the last one reported is offered as a valid/ready beat.
//
// Handshake: out_valid rises only on entry to PRESENT. It stays high, with
// value/blank_mask/err_mask frozen, until a rising edge that sees out_valid &&
// out_ready. out_valid is low from the cycle after that edge. Only reset can
// withdraw an offered frame.
module hex_display_monitor #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic [7*NUM_DIGITS-1:0] seg_in,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   blank_mask,
    output logic [NUM_DIGITS-1:0]   err_mask,
    output logic                    busy
);

    localparam int SW = 7 * NUM_DIGITS;
    localparam int VW = 4 * NUM_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);
    localparam logic [IW-1:0] IDX_LAST = IW'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_SCAN,
        ST_PRESENT
    } state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   seg_q, seg_d;
    logic [CW-1:0]   stab_cnt_q, stab_cnt_d;
    logic            first_flag_q, first_flag_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [SW-1:0]   snapshot_q, snapshot_d;
    logic [SW-1:0]   last_q, last_d;
    logic [VW-1:0]   stage_val_q, stage_val_d;
    logic [NUM_DIGITS-1:0] stage_blank_q, stage_blank_d;
    logic [NUM_DIGITS-1:0] stage_err_q, stage_err_d;
    logic [VW-1:0]   value_q, value_d;
    logic [NUM_DIGITS-1:0] blank_q, blank_d;
    logic [NUM_DIGITS-1:0] err_q, err_d;

    logic [6:0] digit_cur;
    logic [5:0] dec;
    logic       stable;

    // Segment pattern (g..a, active low) -> {err, blank, nibble}.
    function automatic logic [5:0] decode_digit(input logic [6:0] p);
        case (p)
            7'b1000000: decode_digit = {2'b00, 4'h0};
            7'b1111001: decode_digit = {2'b00, 4'h1};
            7'b0100100: decode_digit = {2'b00, 4'h2};
            7'b0110000: decode_digit = {2'b00, 4'h3};
            7'b0011001: decode_digit = {2'b00, 4'h4};
            7'b0010010: decode_digit = {2'b00, 4'h5};
            7'b0000010: decode_digit = {2'b00, 4'h6};
            7'b1111000: decode_digit = {2'b00, 4'h7};
            7'b0000000: decode_digit = {2'b00, 4'h8};
            7'b0010000: decode_digit = {2'b00, 4'h9};
            7'b0001000: decode_digit = {2'b00, 4'hA};
            7'b0000011: decode_digit = {2'b00, 4'hB};
            7'b1000110: decode_digit = {2'b00, 4'hC};
            7'b0100001: decode_digit = {2'b00, 4'hD};
            7'b0000110: decode_digit = {2'b00, 4'hE};
            7'b0001110: decode_digit = {2'b00, 4'hF};
            7'b1111111: decode_digit = {2'b01, 4'h0};
            default:    decode_digit = {2'b10, 4'h0};
        endcase
    endfunction

    assign stable    = (stab_cnt_q == STAB_MAX);
    assign digit_cur = snapshot_q[7*int'(idx_q) +: 7];
    assign dec       = decode_digit(digit_cur);

    // Debounce sampling, next-state logic and staging of decoded digits.
    always_comb begin
        state_d       = state_q;
        seg_d         = seg_in;
        stab_cnt_d    = '0;
        first_flag_d  = first_flag_q;
        idx_d         = idx_q;
        snapshot_d    = snapshot_q;
        last_d        = last_q;
        stage_val_d   = stage_val_q;
        stage_blank_d = stage_blank_q;
        stage_err_d   = stage_err_q;
        value_d       = value_q;
        blank_d       = blank_q;
        err_d         = err_q;

        if (seg_in == seg_q) begin
            stab_cnt_d = stable ? STAB_MAX : stab_cnt_q + 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d      = ST_WAIT;
                    first_flag_d = 1'b1;
                end
            end
            ST_WAIT: begin
                if (!en) begin
                    state_d = ST_IDLE;
                end else if (stable) begin
                    snapshot_d = seg_q;
                    idx_d      = '0;
                    state_d    = ST_SCAN;
                end
            end
            ST_SCAN: begin
                stage_val_d[4*int'(idx_q) +: 4] = dec[3:0];
                stage_blank_d[idx_q]            = dec[4];
                stage_err_d[idx_q]              = dec[5];
                if (idx_q == IDX_LAST) begin
                    if (first_flag_q || (snapshot_q != last_q)) begin
                        value_d      = stage_val_d;
                        blank_d      = stage_blank_d;
                        err_d        = stage_err_d;
                        last_d       = snapshot_q;
                        first_flag_d = 1'b0;
                        state_d      = ST_PRESENT;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
            ST_PRESENT: begin
                if (out_ready) begin
                    state_d = ST_WAIT;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= ST_IDLE;
            seg_q         <= '1;
            stab_cnt_q    <= '0;
            first_flag_q  <= 1'b1;
            idx_q         <= '0;
            snapshot_q    <= '1;
            last_q        <= '1;
            stage_val_q   <= '0;
            stage_blank_q <= '0;
            stage_err_q   <= '0;
            value_q       <= '0;
            blank_q       <= '0;
            err_q         <= '0;
        end else begin
            state_q       <= state_d;
            seg_q         <= seg_d;
            stab_cnt_q    <= stab_cnt_d;
            first_flag_q  <= first_flag_d;
            idx_q         <= idx_d;
            snapshot_q    <= snapshot_d;
            last_q        <= last_d;
            stage_val_q   <= stage_val_d;
            stage_blank_q <= stage_blank_d;
            stage_err_q   <= stage_err_d;
            value_q       <= value_d;
            blank_q       <= blank_d;
            err_q         <= err_d;
        end
    end

    assign out_valid  = (state_q == ST_PRESENT);
    assign busy       = (state_q != ST_IDLE);
    assign value      = value_q;
    assign blank_mask = blank_q;
    assign err_mask   = err_q;

endmodule

// File: tb/tb_hex_display_monitor.sv
// Testbench for hex_display_monitor (4 digits, 4-cycle debounce).
module tb_hex_display_monitor;

    localparam int N  = 4;
    localparam int S  = 4;
    localparam int BW = 6 * N;

    // Segment pattern for each hex digit, g..a, active low.
    localparam logic [6:0] PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic           clk = 1'b0;
    logic           resetn;
    logic           en;
    logic [7*N-1:0] seg_in;
    logic           out_valid;
    logic           out_ready;
    logic [4*N-1:0] value;
    logic [N-1:0]   blank_mask;
    logic [N-1:0]   err_mask;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [BW-1:0] exp_q[$];
    logic [BW-1:0] got_q[$];

    hex_display_monitor #(.NUM_DIGITS(N), .STABLE_CYCLES(S)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .en         (en),
        .seg_in     (seg_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .value      (value),
        .blank_mask (blank_mask),
        .err_mask   (err_mask),
        .busy       (busy)
    );

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Record every beat that the next rising edge will accept.
    always @(negedge clk) begin
        if (resetn && out_valid && out_ready)
            got_q.push_back({value, blank_mask, err_mask});
    end

    // Reference model: hex word shown as segments.
    function automatic logic [7*N-1:0] show_hex(input logic [4*N-1:0] v);
        logic [7*N-1:0] s;
        for (int i = 0; i < N; i++) s[7*i +: 7] = PAT[v[4*i +: 4]];
        return s;
    endfunction

    // Reference model: what should be recovered from a displayed frame.
    function automatic logic [BW-1:0] ref_decode(input logic [7*N-1:0] s);
        logic [4*N-1:0] v = '0;
        logic [N-1:0]   b = '0;
        logic [N-1:0]   e = '0;
        for (int i = 0; i < N; i++) begin
            logic [6:0] p = s[7*i +: 7];
            logic       found = 1'b0;
            if (p == 7'h7F) begin
                b[i] = 1'b1;
            end else begin
                for (int j = 0; j < 16; j++) begin
                    if (!found && p == PAT[j]) begin
                        v[4*i +: 4] = 4'(j);
                        found = 1'b1;
                    end
                end
                if (!found) e[i] = 1'b1;
            end
        end
        return {v, b, e};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input logic [31:0] obs, input logic [31:0] exp, input string tag);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic expect_beat(input logic [BW-1:0] exp, input string tag);
        int t = 0;
        logic [BW-1:0] obs;
        logic [BW-1:0] want;
        exp_q.push_back(exp);
        while (got_q.size() == 0 && t < 60) begin
            step(1);
            t++;
        end
        obs  = (got_q.size() != 0) ? got_q.pop_front() : 'x;
        want = exp_q.pop_front();
        check(32'(obs), 32'(want), tag);
    endtask

    task automatic expect_no_beat(input int cycles, input string tag);
        step(cycles);
        check(32'(got_q.size()), 32'd0, tag);
        got_q.delete();
    endtask

    task automatic wait_valid(input int bound, input string tag);
        int t = 0;
        while (out_valid !== 1'b1 && t < bound) begin
            step(1);
            t++;
        end
        check(32'(out_valid), 32'd1, tag);
    endtask

    logic [7*N-1:0] base;
    logic [7*N-1:0] word;
    logic [7*N-1:0] last_rep;

    initial begin
        resetn    = 1'b0;
        en        = 1'b0;
        out_ready = 1'b0;
        seg_in    = '1;
        step(3);
        check(32'(out_valid), 32'd0, "rst_valid");
        check(32'(busy), 32'd0, "rst_busy");
        check(32'(value), 32'd0, "rst_value");
        check(32'(blank_mask), 32'd0, "rst_blank");
        check(32'(err_mask), 32'd0, "rst_err");

        // First frame: latency and hold while not ready.
        seg_in = show_hex(16'h1234);
        step(1);
        resetn = 1'b1;
        en     = 1'b1;
        step(1);
        for (int i = 1; i <= 9; i++) begin
            step(1);
            if (i == 8) check(32'(out_valid), 32'd0, "lat_early");
            if (i == 9) check(32'(out_valid), 32'd1, "lat_edge9");
        end
        check(32'(value), 32'h1234, "first_value");
        check(32'({blank_mask, err_mask}), 32'd0, "first_masks");
        step(10);
        check(32'(out_valid), 32'd1, "hold_valid");
        check(32'(value), 32'h1234, "hold_value");
        out_ready = 1'b1;
        expect_beat({16'h1234, 4'h0, 4'h0}, "first_beat");
        expect_no_beat(15, "no_rereport_first");

        // Every table pattern on digit 0.
        for (int h = 0; h < 16; h++) begin
            seg_in = {PAT[0], PAT[0], PAT[0], PAT[h]};
            expect_beat({12'h000, 4'(h), 8'h00}, $sformatf("sweep_%0d", h));
        end

        // Blank and unrecognised digits.
        seg_in = {7'h7F, 7'b1010101, PAT[5], PAT[10]};
        expect_beat({16'h005A, 4'b1000, 4'b0100}, "blank_err");

        // Short glitches are filtered; an unchanged frame is not re-reported.
        base   = show_hex(16'h1234);
        seg_in = base;
        expect_beat({16'h1234, 4'h0, 4'h0}, "glitch_base");
        for (int g = 0; g < 5; g++) begin
            int len;
            len = (g == 0) ? 3 : $urandom_range(1, S);
            seg_in = {base[27:7], PAT[7]};
            step(len);
            seg_in = base;
            step($urandom_range(S + 2, S + 8));
        end
        expect_no_beat(50, "glitch_none");

        // Display changes while a frame is waiting are not mixed into it.
        seg_in = show_hex(16'h0000);
        expect_beat({16'h0000, 4'h0, 4'h0}, "pre_hold");
        out_ready = 1'b0;
        seg_in = show_hex(16'h1234);
        wait_valid(40, "hold_offer");
        check(32'(value), 32'h1234, "hold_offer_value");
        seg_in = show_hex(16'hBEEF);
        step(20);
        check(32'(out_valid), 32'd1, "hold_beef_valid");
        check(32'(value), 32'h1234, "hold_beef_value");
        out_ready = 1'b1;
        expect_beat({16'h1234, 4'h0, 4'h0}, "held_frame");
        expect_beat({16'hBEEF, 4'h0, 4'h0}, "next_frame");

        // Reset while scanning, then the unchanged display is reported once.
        seg_in = show_hex(16'h0000);
        step(7);
        check(32'({busy, out_valid}), 32'b10, "mid_scan");
        resetn = 1'b0;
        en     = 1'b0;
        step(1);
        check(32'(out_valid), 32'd0, "scanrst_valid");
        check(32'(busy), 32'd0, "scanrst_busy");
        check(32'(value), 32'd0, "scanrst_value");
        check(32'({blank_mask, err_mask}), 32'd0, "scanrst_masks");
        resetn = 1'b1;
        step(1);
        en = 1'b1;
        expect_beat({16'h0000, 4'h0, 4'h0}, "post_reset_first");
        expect_no_beat(30, "post_reset_once");

        // Disable then re-enable re-reports the same frame once.
        en = 1'b0;
        step(2);
        check(32'(busy), 32'd0, "idle_busy");
        en = 1'b1;
        expect_beat({16'h0000, 4'h0, 4'h0}, "reenable_first");
        expect_no_beat(20, "reenable_once");

        // Random frames with blanks, garbage and repeats, random ready delay.
        last_rep = show_hex(16'h0000);
        for (int it = 0; it < 24; it++) begin
            if ($urandom_range(0, 5) == 0) begin
                word = last_rep;
            end else begin
                for (int d = 0; d < N; d++) begin
                    case ($urandom_range(0, 9))
                        0:       word[7*d +: 7] = 7'h7F;
                        1:       word[7*d +: 7] = 7'($urandom_range(0, 127));
                        default: word[7*d +: 7] = PAT[$urandom_range(0, 15)];
                    endcase
                end
            end
            if (word != last_rep) begin
                out_ready = 1'b0;
                seg_in    = word;
                wait_valid(40, $sformatf("rnd_offer_%0d", it));
                step($urandom_range(0, 4));
                out_ready = 1'b1;
                expect_beat(ref_decode(word), $sformatf("rnd_beat_%0d", it));
                last_rep = word;
            end else begin
                out_ready = 1'b1;
                seg_in    = word;
                expect_no_beat(20, $sformatf("rnd_repeat_%0d", it));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
